// File: rtl/ocr_load_controller.sv
// Image load sequencer: clears the image buffer, streams IMG_BYTES receiver bytes into it,
// starts the BNN once the buffer reports full, and hands the class result to the host.
module ocr_load_controller #(
    parameter int IMG_BYTES      = 113,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SETTLE_MAX     = 8,
    parameter int RES_W          = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic             abort,
    output logic             buf_clear,
    output logic             buf_we,
    output logic [7:0]       buf_data,
    input  logic             buf_full,
    output logic             bnn_start,
    input  logic             bnn_done,
    input  logic [RES_W-1:0] bnn_result,
    output logic             result_valid,
    output logic [RES_W-1:0] result_data,
    input  logic             result_ack,
    output logic             busy,
    output logic             error,
    output logic [6:0]       byte_count
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int ST_W = (SETTLE_MAX > 1) ? $clog2(SETTLE_MAX) : 1;
    // The idle counter fires on the edge that would take it to TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 2);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(SETTLE_MAX - 1);
    localparam logic [6:0]      BC_LAST = 7'(IMG_BYTES - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_LOAD,
        S_SETTLE,
        S_WAIT_DONE,
        S_RESULT
    } state_t;

    state_t            state_reg, state_next;
    logic [6:0]        byte_count_reg, byte_count_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic [ST_W-1:0]   settle_cnt_reg, settle_cnt_next;
    logic              buf_we_reg, buf_we_next;
    logic [7:0]        buf_data_reg, buf_data_next;
    logic              bnn_start_reg, bnn_start_next;
    logic              result_valid_reg, result_valid_next;
    logic [RES_W-1:0]  result_data_reg, result_data_next;
    logic              error_reg, error_next;
    logic              busy_reg, busy_next;
    logic              handshake;

    assign rx_ready     = (state_reg == S_LOAD) & ~abort;
    assign handshake    = rx_valid & rx_ready;
    assign buf_clear    = (state_reg == S_CLEAR);
    assign buf_we       = buf_we_reg;
    assign buf_data     = buf_data_reg;
    assign bnn_start    = bnn_start_reg;
    assign result_valid = result_valid_reg;
    assign result_data  = result_data_reg;
    assign error        = error_reg;
    assign busy         = busy_reg;
    assign byte_count   = byte_count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= S_CLEAR;
            byte_count_reg   <= '0;
            to_cnt_reg       <= '0;
            settle_cnt_reg   <= '0;
            buf_we_reg       <= 1'b0;
            buf_data_reg     <= '0;
            bnn_start_reg    <= 1'b0;
            result_valid_reg <= 1'b0;
            result_data_reg  <= '0;
            error_reg        <= 1'b0;
            busy_reg         <= 1'b1;
        end else begin
            state_reg        <= state_next;
            byte_count_reg   <= byte_count_next;
            to_cnt_reg       <= to_cnt_next;
            settle_cnt_reg   <= settle_cnt_next;
            buf_we_reg       <= buf_we_next;
            buf_data_reg     <= buf_data_next;
            bnn_start_reg    <= bnn_start_next;
            result_valid_reg <= result_valid_next;
            result_data_reg  <= result_data_next;
            error_reg        <= error_next;
            busy_reg         <= busy_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        byte_count_next   = byte_count_reg;
        to_cnt_next       = to_cnt_reg;
        settle_cnt_next   = settle_cnt_reg;
        buf_we_next       = 1'b0;
        buf_data_next     = buf_data_reg;
        bnn_start_next    = 1'b0;
        result_valid_next = result_valid_reg;
        result_data_next  = result_data_reg;
        error_next        = error_reg;

        if (abort && state_reg != S_CLEAR) begin
            // Abort beats every other event and leaves the error flag alone.
            state_next        = S_CLEAR;
            result_valid_next = 1'b0;
        end else begin
            unique case (state_reg)
                S_CLEAR: begin
                    byte_count_next   = '0;
                    to_cnt_next       = '0;
                    result_valid_next = 1'b0;
                    state_next        = S_LOAD;
                end
                S_LOAD: begin
                    if (handshake) begin
                        buf_we_next     = 1'b1;
                        buf_data_next   = rx_data;
                        byte_count_next = byte_count_reg + 7'd1;
                        to_cnt_next     = '0;
                        if (byte_count_reg == 7'd0) begin
                            error_next = 1'b0;
                        end
                        if (byte_count_reg == BC_LAST) begin
                            settle_cnt_next = '0;
                            state_next      = S_SETTLE;
                        end
                    end else if (byte_count_reg != 7'd0) begin
                        if (to_cnt_reg == TO_LAST) begin
                            to_cnt_next = '0;
                            error_next  = 1'b1;
                            state_next  = S_CLEAR;
                        end else begin
                            to_cnt_next = to_cnt_reg + TO_W'(1);
                        end
                    end
                end
                S_SETTLE: begin
                    if (buf_full) begin
                        bnn_start_next = 1'b1;
                        state_next     = S_WAIT_DONE;
                    end else if (settle_cnt_reg == ST_LAST) begin
                        error_next = 1'b1;
                        state_next = S_CLEAR;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + ST_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (bnn_done) begin
                        result_data_next  = bnn_result;
                        result_valid_next = 1'b1;
                        state_next        = S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (result_ack) begin
                        result_valid_next = 1'b0;
                        state_next        = S_CLEAR;
                    end
                end
                default: state_next = S_CLEAR;
            endcase
        end

        busy_next = !((state_next == S_LOAD) && (byte_count_next == 7'd0));
    end

endmodule

// File: tb/tb_ocr_load_controller.sv
// Randomized scoreboard bench for ocr_load_controller: stimulus pushes expected writes,
// start/error timing and results into queues; a negedge monitor pops and compares.
module tb_ocr_load_controller;

    localparam int IMG   = 113;
    localparam int TOUT  = 64;
    localparam int SMAX  = 8;
    localparam int RES_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             rx_valid = 1'b0;
    logic [7:0]       rx_data = '0;
    logic             rx_ready;
    logic             abort = 1'b0;
    logic             buf_clear;
    logic             buf_we;
    logic [7:0]       buf_data;
    logic             buf_full;
    logic             bnn_start;
    logic             bnn_done = 1'b0;
    logic [RES_W-1:0] bnn_result = '0;
    logic             result_valid;
    logic [RES_W-1:0] result_data;
    logic             result_ack = 1'b0;
    logic             busy;
    logic             error;
    logic [6:0]       byte_count;

    ocr_load_controller #(
        .IMG_BYTES(IMG), .TIMEOUT_CYCLES(TOUT), .SETTLE_MAX(SMAX), .RES_W(RES_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .abort(abort), .buf_clear(buf_clear), .buf_we(buf_we),
        .buf_data(buf_data), .buf_full(buf_full), .bnn_start(bnn_start),
        .bnn_done(bnn_done), .bnn_result(bnn_result), .result_valid(result_valid),
        .result_data(result_data), .result_ack(result_ack), .busy(busy),
        .error(error), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Image buffer model: full flag registered one edge after the write count settles.
    int   wcnt = 0;
    logic full_reg = 1'b0;
    bit   stuck = 1'b0;
    always @(posedge clk) begin
        if (buf_clear === 1'b1) begin
            wcnt     <= 0;
            full_reg <= 1'b0;
        end else begin
            if (buf_we === 1'b1) wcnt <= wcnt + 1;
            full_reg <= (wcnt >= IMG);
        end
    end
    assign buf_full = full_reg & ~stuck;

    int n_checks = 0;
    int n_pass   = 0;
    int last_hs  = 0;
    int clr_cnt  = 0;
    bit mon_en   = 1'b0;

    logic [7:0] exp_wr_q[$];
    int         exp_start_q[$];
    int         exp_err_q[$];
    int         exp_res_q[$];
    int         exp_rvlen_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        $display("FAIL unexpected_%s: event seen with nothing expected (cycle %0d)", name, cyc);
    endtask

    // Monitor
    logic rv_prev = 1'b0;
    logic err_prev = 1'b0;
    int   rv_len = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (buf_clear) clr_cnt++;
            if (buf_we) begin
                if (exp_wr_q.size() == 0) unexpected("buf_we");
                else chk("buf_data", 32'(buf_data), 32'(exp_wr_q.pop_front()));
            end
            if (bnn_start) begin
                if (exp_start_q.size() == 0) unexpected("bnn_start");
                else chk("bnn_start_cycle", cyc, exp_start_q.pop_front());
            end
            if (result_valid && !rv_prev) begin
                rv_len = 0;
                if (exp_res_q.size() == 0) unexpected("result_valid");
                else chk("result_data", 32'(result_data), exp_res_q.pop_front());
            end
            if (result_valid) rv_len++;
            if (!result_valid && rv_prev) begin
                if (exp_rvlen_q.size() == 0) unexpected("result_valid_fall");
                else chk("result_valid_len", rv_len, exp_rvlen_q.pop_front());
            end
            if (error && !err_prev) begin
                if (exp_err_q.size() == 0) unexpected("error");
                else chk("error_rise_cycle", cyc, exp_err_q.pop_front());
            end
            rv_prev  = result_valid;
            err_prev = error;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (n < budget && (exp_wr_q.size() + exp_start_q.size() + exp_err_q.size()
                              + exp_res_q.size() + exp_rvlen_q.size()) != 0) begin
            step();
            n++;
        end
        chk({name, "_pending"}, exp_wr_q.size() + exp_start_q.size() + exp_err_q.size()
            + exp_res_q.size() + exp_rvlen_q.size(), 0);
    endtask

    task automatic send_bytes(input int n, input bit rnd, input int max_gap, input int glitch_at);
        int gap;
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gap; g++) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                step();
            end
            b = rnd ? 8'($urandom) : 8'(i);
            rx_valid   = 1'b1;
            rx_data    = b;
            bnn_done   = (i == glitch_at);
            result_ack = (i == glitch_at);
            bnn_result = 4'($urandom);
            #1;
            chk("rx_ready", 32'(rx_ready), 1);
            exp_wr_q.push_back(b);
            last_hs = cyc + 1;
            step();
            bnn_done   = 1'b0;
            result_ack = 1'b0;
        end
        rx_valid = 1'b0;
    endtask

    task automatic expect_start();
        exp_start_q.push_back(last_hs + 3);
        wait_drain("bnn_start", 20);
        chk("byte_count_full", 32'(byte_count), IMG);
        chk("busy_wait_done", 32'(busy), 1);
    endtask

    task automatic finish_result(input int delay, input int res, input int hold, input bit ack_glitch);
        for (int i = 0; i < delay; i++) begin
            result_ack = ack_glitch;
            step();
        end
        result_ack = 1'b0;
        chk("no_result_before_done", 32'(result_valid), 0);
        bnn_done   = 1'b1;
        bnn_result = 4'(res);
        exp_res_q.push_back(res & 15);
        exp_rvlen_q.push_back(hold + 1);
        step();
        bnn_done   = 1'b0;
        bnn_result = 4'($urandom);
        for (int i = 0; i < hold; i++) step();
        chk("result_valid_held", 32'(result_valid), 1);
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
        chk("clear_after_ack", 32'(buf_clear), 1);
        chk("result_valid_fell", 32'(result_valid), 0);
        step();
        chk("byte_count_after_clear", 32'(byte_count), 0);
        chk("busy_idle", 32'(busy), 0);
        wait_drain("result", 4);
    endtask

    initial begin
        int clr0;
        // Reset
        repeat (3) step();
        chk("rst_buf_we", 32'(buf_we), 0);
        chk("rst_bnn_start", 32'(bnn_start), 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_buf_data", 32'(buf_data), 0);
        chk("rst_result_data", 32'(result_data), 0);
        chk("rst_byte_count", 32'(byte_count), 0);
        chk("rst_buf_clear", 32'(buf_clear), 1);
        rst_n = 1'b1;
        #1;
        chk("clear_first_cycle", 32'(buf_clear), 1);
        step();
        mon_en = 1'b1;
        chk("clear_one_cycle", 32'(buf_clear), 0);
        chk("rx_ready_load", 32'(rx_ready), 1);
        chk("busy_load_empty", 32'(busy), 0);

        // No timeout armed while the image has not started
        clr0 = clr_cnt;
        repeat (80) step();
        chk("idle_no_error", 32'(error), 0);
        chk("idle_no_clear", clr_cnt - clr0, 0);

        // Image 0x00..0x70 back-to-back, result 7, ack after 10 cycles
        send_bytes(IMG, 1'b0, 0, -1);
        expect_start();
        finish_result(2, 7, 10, 1'b0);

        // Inter-byte timeout after 5 bytes
        clr0 = clr_cnt;
        send_bytes(5, 1'b1, 0, -1);
        exp_err_q.push_back(last_hs + TOUT - 1);
        wait_drain("timeout", 100);
        step();
        chk("timeout_error", 32'(error), 1);
        chk("timeout_one_clear", clr_cnt - clr0, 1);
        chk("timeout_byte_count", 32'(byte_count), 0);
        send_bytes(1, 1'b1, 0, -1);
        chk("first_byte_clears_error", 32'(error), 0);
        send_bytes(IMG - 1, 1'b1, 0, -1);
        expect_start();
        finish_result(0, int'($urandom_range(15, 0)), 0, 1'b0);

        // buf_full never arrives
        stuck = 1'b1;
        send_bytes(IMG, 1'b1, 0, -1);
        exp_err_q.push_back(last_hs + SMAX);
        wait_drain("settle_timeout", 30);
        stuck = 1'b0;
        chk("settle_error", 32'(error), 1);
        chk("settle_byte_count", 32'(byte_count), 0);

        // Abort in idle LOAD keeps a set error flag
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle_clear", 32'(buf_clear), 1);
        chk("abort_keeps_error", 32'(error), 1);
        step();
        chk("abort_idle_error_after", 32'(error), 1);
        chk("abort_idle_reload", 32'(buf_clear), 0);

        // Abort with a byte offered at byte_count == 50
        send_bytes(50, 1'b1, 0, -1);
        chk("abort_pre_count", 32'(byte_count), 50);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        abort    = 1'b1;
        #1;
        chk("abort_rx_ready", 32'(rx_ready), 0);
        step();
        rx_valid = 1'b0;
        abort    = 1'b0;
        chk("abort_load_clear", 32'(buf_clear), 1);
        chk("abort_load_no_we", 32'(buf_we), 0);
        chk("abort_load_error", 32'(error), 0);
        step();
        chk("abort_load_count", 32'(byte_count), 0);
        chk("abort_load_busy", 32'(busy), 0);

        // Stray bnn_done/result_ack in LOAD and result_ack in WAIT_DONE
        send_bytes(IMG, 1'b1, 0, 20);
        chk("glitch_no_result", 32'(result_valid), 0);
        expect_start();
        finish_result(5, int'($urandom_range(15, 0)), int'($urandom_range(4, 0)), 1'b1);

        // Abort in WAIT_DONE, late bnn_done must be ignored
        send_bytes(IMG, 1'b1, 1, -1);
        expect_start();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_wait_clear", 32'(buf_clear), 1);
        step();
        bnn_done   = 1'b1;
        bnn_result = 4'd5;
        step();
        bnn_done = 1'b0;
        repeat (3) step();
        chk("late_done_ignored", 32'(result_valid), 0);

        // Randomized images
        for (int k = 0; k < 4; k++) begin
            send_bytes(IMG, 1'b1, 3, -1);
            expect_start();
            finish_result(int'($urandom_range(6, 0)), int'($urandom_range(15, 0)),
                          int'($urandom_range(5, 0)), 1'b0);
        end

        wait_drain("final", 10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ocr_load_controller.md
# ocr_load_controller

Sequencing controller between the byte-stream receiver and the 904-bit image buffer / BNN core. It clears the buffer, accepts exactly IMG_BYTES bytes from the receiver and writes them into the buffer. It then confirms the buffer reports full, starts inference and presents the classification result to the host through a valid/ack handshake. It also enforces an inter-byte timeout and provides a host abort.

## Interface
- IMG_BYTES, 113: bytes per image (113 × 8 = 904 buffer bits).
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between bytes once an image has started.
- SETTLE_MAX, 8: maximum cycles to wait for buf_full after the last byte.
- RES_W, 4: width of the BNN class result.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: one clock; reset is synchronous and active-low.
- rx_valid  in  1  receiver byte valid.
- rx_data  in  8  receiver byte.
- rx_ready  out  1  controller accepts byte; handshake = rx_valid & rx_ready.
- abort  in  1  host abort; return to CLEAR.
- buf_clear  out  1  image buffer clear.
- buf_we  out  1  image buffer write enable.
- buf_data  out  8  image buffer write byte.
- buf_full  in  1  image buffer full flag (registered in buffer).
- bnn_start  out  1  one-cycle inference start pulse.
- bnn_done  in  1  inference complete, one-cycle pulse.
- bnn_result  in  RES_W  class index, valid with bnn_done.
- result_valid  out  1  result available.
- result_data  out  RES_W  latched class index.
- result_ack  in  1  host consumed result.
- busy  out  1  high unless in LOAD with byte_count == 0.
- error  out  1  sticky fault flag.
- byte_count  out  7  bytes accepted for the current image.

## Operation
- States: CLEAR, LOAD, SETTLE, WAIT_DONE, RESULT. Reset state is CLEAR.
- Decoded outputs:
  - buf_clear = (state == CLEAR).
  - rx_ready = (state == LOAD) & ~abort.
  - All other outputs are registered.
- CLEAR: byte_count ← 0, timeout counter ← 0, result_valid ← 0. Always go to LOAD next cycle; CLEAR lasts exactly one cycle.
- LOAD, on handshake:
  - buf_data ← rx_data and buf_we ← 1 (one cycle).
  - byte_count += 1; timeout counter ← 0.
  - The first byte of an image (byte_count == 0) clears error.
  - When the handshake takes byte_count to IMG_BYTES, go to SETTLE.
- LOAD timeout: while byte_count ≠ 0 and there is no handshake, the timeout counter increments. When it reaches TIMEOUT_CYCLES−1: error ← 1, go to CLEAR. No timeout is armed while byte_count == 0.
- SETTLE: count cycles in state.
  - buf_full == 1: bnn_start ← 1 for one cycle, go to WAIT_DONE.
  - SETTLE_MAX cycles elapse without buf_full: error ← 1, go to CLEAR.
- WAIT_DONE: on bnn_done, result_data ← bnn_result, result_valid ← 1, go to RESULT. There is no timeout.
- RESULT: hold result_valid and result_data. On result_ack, go to CLEAR; result_valid falls on the same edge.
- abort (any state except CLEAR): next state is CLEAR. It has priority over handshake, bnn_done and result_ack. result_valid drops, and error is unchanged. A pending bnn_done arriving later is ignored.
- Ignored inputs:
  - bnn_done outside WAIT_DONE.
  - result_ack outside RESULT.
  - buf_full outside SETTLE.
- Counter widths:
  - byte_count is 7 bits, and IMG_BYTES ≤ 127 is required.
  - The timeout counter is $clog2(TIMEOUT_CYCLES) bits, with no wrap: it is cleared on reaching its limit.

## Timing
- Reset values (rst_n sampled low):
  - state = CLEAR.
  - buf_we, bnn_start, result_valid, error = 0.
  - buf_data, result_data, byte_count = 0.
- Because the reset state is CLEAR, buf_clear is high in the first cycle after rst_n rises.
- Byte write latency: buf_we/buf_data are valid the cycle after the handshake. Back-to-back handshakes give back-to-back writes. Maximum throughput is 1 byte/clk.
- Last byte: handshake at edge T0 (enter SETTLE). buf_we is high in the cycle after T0, and the buffer asserts buf_full after edge T2. bnn_start is high in the cycle following the first SETTLE cycle that samples buf_full == 1. Nominal gap from last handshake to bnn_start is 3 cycles.
- Result: result_valid rises the cycle after bnn_done and falls the cycle after result_ack. The next image's CLEAR cycle immediately follows.
- Mid-image reset or abort leaves stale bytes in the buffer only until the following CLEAR cycle.

## Test plan
- Reset, then 113 back-to-back bytes 0x00..0x70 → buf_clear is a 1-cycle pulse after reset; 113 buf_we pulses with matching buf_data; byte_count = 113; bnn_start exactly once, 3 cycles after the last handshake.
- bnn_done with bnn_result = 4'd7, result_ack held low 10 cycles, then pulsed → result_valid high for 11 cycles, result_data = 7; CLEAR occurs the cycle after ack, then byte_count = 0.
- TIMEOUT_CYCLES = 64: send 5 bytes, then stall → error = 1 exactly 63 idle cycles after the 5th handshake; one buf_clear; next first byte clears error.
- Model buf_full stuck low → error = 1 after SETTLE_MAX cycles in SETTLE; no bnn_start.
- abort asserted with rx_valid in LOAD (byte_count = 50) → rx_ready = 0 that cycle; no buf_we; CLEAR next; byte_count = 0; error unchanged.
- bnn_done pulsed during LOAD and result_ack during WAIT_DONE → both ignored; no result_valid until a real bnn_done in WAIT_DONE.
